vram_responder: RTL
===================

# vram_responder

Byte-wide video RAM that answers the video generator's tile fetches (tile index table and tile pattern data) and gives a CPU port shared access to the same storage. A fixed time-slot arbiter runs one access per clock. Every fourth slot is reserved for the video side, so video reads have a bounded latency, and the CPU is served in the remaining slots through a req/ack handshake. It sits between the video generator's memory port (clocked from the same I_clock) and the system bus.

## Interface
Parameters:
- P_base, 16'h4000: first byte address decoded by this block.
- P_depth, 4096: number of bytes. Power of two, at most 65536. Decoded range is P_base .. P_base+P_depth-1.

Ports:
- I_clock  in  1  system clock. Same clock as the video generator's memory clock.
- I_reset  in  1  reset, asynchronous, active-low.
- I_vid_addr  in  16  video fetch address, registered by the video generator.
- O_vid_data  out  8  video read data, held between video slots.
- I_cpu_req  in  1  CPU access request. Held until O_cpu_ack.
- I_cpu_we  in  1  1 = write, 0 = read. Stable while I_cpu_req is high.
- I_cpu_addr  in  16  CPU byte address. Stable while I_cpu_req is high.
- I_cpu_wdata  in  8  CPU write data. Stable while I_cpu_req is high.
- O_cpu_ack  out  1  single-cycle completion pulse.
- O_cpu_rdata  out  8  CPU read data, valid while O_cpu_ack=1 and held afterwards.

## Operation
- Slot counter: 2-bit `slot`, increments every clock and wraps 3→0.
  - Slot 0: video slot.
  - Slots 1, 2, 3: CPU slots.
- Address decode: in_range = (addr - P_base) < P_depth, computed in 16-bit unsigned arithmetic so that wrap-around below P_base counts as out of range. RAM index = (addr - P_base) modulo P_depth.
- Video slot:
  - RAM is read at I_vid_addr as sampled in that cycle.
  - O_vid_data is loaded on the next clock edge: RAM byte if in range, 8'h00 if out of range.
  - O_vid_data does not change at any other time.
- CPU FSM, states C_IDLE and C_ACK:
  - C_IDLE, CPU slot, I_cpu_req=1: perform the access this cycle and go to C_ACK.
    - Write, in range: RAM byte updated at this edge.
    - Write, out of range: dropped.
    - Read: O_cpu_rdata is loaded at this edge with the RAM byte, or 8'hFF if out of range.
  - C_IDLE, slot 0 or I_cpu_req=0: stay in C_IDLE.
  - C_ACK: O_cpu_ack=1 for this one cycle. Return to C_IDLE unconditionally. No request is accepted in this cycle, whatever the slot.
- O_cpu_ack is a registered output equal to (state == C_ACK).
- A request still high after its ack is treated as a new request.
- Maximum CPU throughput is one access per 2 clocks, further stalled by slot 0.
- Simultaneous events:
  - CPU write in slot 3 followed by a video read of the same address in the next slot 0: the video read returns the new byte.
  - A CPU read never observes a half-completed video access. There is only one RAM port and one access per cycle.
- RAM contents are not reset. They are undefined until written.

## Timing
- Reset values:
  - slot=0, state=C_IDLE.
  - O_vid_data=8'h00, O_cpu_ack=0, O_cpu_rdata=8'h00.
- The first cycle after reset release is slot 0.
- Video latency: I_vid_addr change to valid O_vid_data is at most 5 clocks (up to 4 waiting for slot 0, plus 1). This is inside the generator's 8-clock address-to-sample window.
- CPU latency:
  - Request seen in C_IDLE on a CPU slot: ack 1 clock later.
  - Request arriving during slot 0: ack 2 clocks later.
  - Worst case, request arriving in a C_ACK cycle that is slot 3: the next cycle is slot 0, so ack comes 3 clocks later.
- Reset asserted mid-operation:
  - A pending ack is cancelled and not re-issued.
  - A write already committed to RAM persists.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert I_reset=0 for 3 clocks, then release → O_vid_data=00, O_cpu_ack=0, O_cpu_rdata=00. The first video slot is the first cycle after release.
- CPU write then video read: write 8'hA5 to 16'h4803 in a CPU slot; then set I_vid_addr=16'h4803 → O_vid_data=A5 within 5 clocks and stable until the address changes.
- CPU read after write: write 8'h3C to 16'h4000, then read 16'h4000 → O_cpu_ack pulses exactly 1 cycle and O_cpu_rdata=3C.
- Out of range:
  - CPU read of 16'h3FFF → ack with rdata=FF.
  - CPU write of 16'h5000 → ack, and RAM is unchanged (16'h4000 still reads 3C).
  - I_vid_addr=16'h5000 → O_vid_data=00.
- Back-to-back plus slot stall: hold I_cpu_req=1 for 8 writes to 16'h4000..4007, starting the request in slot 1.
  - Acks appear on alternate cycles, with one extra stall each time slot 0 falls in the next acceptance cycle.
  - Exactly 8 acks; all 8 bytes then read back correctly.
- Reset mid-access: assert I_reset in the cycle a write is accepted → no ack after reset, and the written byte reads back correct.

Source files
------------

// File: rtl/vram_responder.sv
// vram_responder: byte VRAM with a fixed 4-slot arbiter, slot 0 for video reads and slots 1-3 for CPU req/ack accesses.
module vram_responder #(
  parameter logic [15:0] P_base = 16'h4000,
  parameter int P_depth = 4096
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_vid_addr,
  output logic [7:0]  O_vid_data,
  input  logic        I_cpu_req,
  input  logic        I_cpu_we,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wdata,
  output logic        O_cpu_ack,
  output logic [7:0]  O_cpu_rdata
);
  localparam int AW = $clog2(P_depth);
  typedef enum logic {C_IDLE, C_ACK} state_t;
  logic [7:0] mem_q [P_depth];
  logic [1:0] slot_q;
  state_t state_q;
  logic [7:0] vid_q, rdata_q;
  logic [15:0] vid_off, cpu_off;
  logic vid_in, cpu_in, cpu_go;
  // Offsets wrap in 16 bits, so addresses below P_base fall out of range.
  always_comb begin
    vid_off = I_vid_addr - P_base;
    cpu_off = I_cpu_addr - P_base;
    vid_in = {1'b0, vid_off} < 17'(P_depth);
    cpu_in = {1'b0, cpu_off} < 17'(P_depth);
    cpu_go = state_q == C_IDLE && slot_q != 2'd0 && I_cpu_req;
  end
  always_ff @(posedge I_clock)
    if (cpu_go && I_cpu_we && cpu_in) mem_q[cpu_off[AW-1:0]] <= I_cpu_wdata;
  always_ff @(posedge I_clock or negedge I_reset)
    if (!I_reset) begin
      slot_q <= 2'd0;
      state_q <= C_IDLE;
      vid_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      slot_q <= slot_q + 2'd1;
      state_q <= cpu_go ? C_ACK : C_IDLE;
      if (slot_q == 2'd0) vid_q <= vid_in ? mem_q[vid_off[AW-1:0]] : 8'h00;
      if (cpu_go && !I_cpu_we) rdata_q <= cpu_in ? mem_q[cpu_off[AW-1:0]] : 8'hFF;
    end
  assign O_vid_data = vid_q;
  assign O_cpu_ack = state_q == C_ACK;
  assign O_cpu_rdata = rdata_q;
endmodule
